// File: rtl/minne_ctrl.sv
// Sequential access controller driving the minne 3-to-8 word-line decoder and an 8-word store.
// Optional per-word even parity is enabled with `define MINNE_CTRL_PARITY_EN.
module minne_ctrl #(
    parameter int DATA_W      = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              A2,
    output logic              A1,
    output logic              A0,
    output logic              Select,
    input  logic [7:0]        wl,
    output logic              dec_err,
    output logic              par_err
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t              state_q, state_d;
    logic                we_q, we_d;
    logic [2:0]          addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                dec_err_q, dec_err_d;
    logic [DATA_W-1:0]   mem_q [8];
    logic [DATA_W-1:0]   mem_d [8];
    logic                wl_ok;
`ifdef MINNE_CTRL_PARITY_EN
    logic [7:0]          par_q, par_d;
    logic                par_err_q, par_err_d;
`endif

    // A decode is good only if exactly the latched word line fired.
    assign wl_ok = (wl == (8'b1 << addr_q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            rdata_q   <= '0;
            dec_err_q <= 1'b0;
            mem_q     <= '{default: '0};
`ifdef MINNE_CTRL_PARITY_EN
            par_q     <= '0;
            par_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            dec_err_q <= dec_err_d;
            mem_q     <= mem_d;
`ifdef MINNE_CTRL_PARITY_EN
            par_q     <= par_d;
            par_err_q <= par_err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid)   state_d = SETUP;
            SETUP:                    state_d = ACCESS;
            ACCESS:  if (cnt_q == '0) state_d = RESP;
            RESP:    if (rsp_ready)   state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
    end

    always_comb begin
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        dec_err_d = dec_err_q;
        mem_d     = mem_q;
`ifdef MINNE_CTRL_PARITY_EN
        par_d     = par_q;
        par_err_d = par_err_q;
`endif
        if (state_q == IDLE && req_valid) begin
            we_d    = req_we;
            addr_d  = req_addr;
            wdata_d = req_wdata;
        end
        if (state_q == SETUP)
            cnt_d = 4'(WAIT_CYCLES - 1);
        if (state_q == ACCESS) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 4'd1;
            end else if (wl_ok) begin
                if (we_q) begin
                    mem_d[addr_q] = wdata_q;
                    rdata_d       = wdata_q;
`ifdef MINNE_CTRL_PARITY_EN
                    par_d[addr_q] = ^wdata_q;
`endif
                end else begin
                    rdata_d = mem_q[addr_q];
`ifdef MINNE_CTRL_PARITY_EN
                    par_err_d = (^mem_q[addr_q]) != par_q[addr_q];
`endif
                end
            end else begin
                rdata_d   = '0;
                dec_err_d = 1'b1;
            end
        end
`ifdef MINNE_CTRL_PARITY_EN
        if (state_q == RESP && rsp_ready)
            par_err_d = 1'b0;
`endif
    end

    always_comb begin
        req_ready = (state_q == IDLE);
        Select    = (state_q == ACCESS);
        rsp_valid = (state_q == RESP);
    end

    assign {A2, A1, A0} = addr_q;
    assign rsp_rdata    = rdata_q;
    assign dec_err      = dec_err_q;
`ifdef MINNE_CTRL_PARITY_EN
    assign par_err      = par_err_q;
`else
    assign par_err      = 1'b0;
`endif
endmodule

// File: tb/tb_minne_ctrl.sv
// Randomized bench for minne_ctrl: cycle-timed transaction model plus literal spot checks.
module tb_minne_ctrl;
    localparam int W  = 1;
    localparam int W3 = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       req_valid = 0, req_we = 0, rsp_ready = 0;
    logic [2:0] req_addr = 0;
    logic [7:0] req_wdata = 0;
    logic       req_ready, rsp_valid, A2, A1, A0, Select, dec_err, par_err;
    logic [7:0] rsp_rdata, wl;
    logic [2:0] a_bus;
    int         fault = 0;

    logic       b_req_valid = 0, b_req_we = 0, b_rsp_ready = 1;
    logic [2:0] b_req_addr = 0;
    logic [7:0] b_req_wdata = 0;
    logic       b_req_ready, b_rsp_valid, b_A2, b_A1, b_A0, b_Select, b_dec_err, b_par_err;
    logic [7:0] b_rsp_rdata, b_wl;

    // Decoder stand-in: ideal, or one of three fault shapes.
    function automatic logic [7:0] drive_wl(input int f, input logic [2:0] a);
        logic [2:0] a1, a3;
        a1 = a + 3'd1;
        a3 = a + 3'd3;
        case (f)
            1:       return 8'h00;
            2:       return 8'h01 << a1;
            3:       return (8'h01 << a) | (8'h01 << a3);
            default: return 8'h01 << a;
        endcase
    endfunction

    assign a_bus = {A2, A1, A0};
    assign wl    = Select ? drive_wl(fault, a_bus) : 8'h00;
    assign b_wl  = b_Select ? (8'h01 << {b_A2, b_A1, b_A0}) : 8'h00;

    minne_ctrl #(.DATA_W(8), .WAIT_CYCLES(W)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .A2(A2), .A1(A1), .A0(A0), .Select(Select), .wl(wl),
        .dec_err(dec_err), .par_err(par_err));

    minne_ctrl #(.DATA_W(8), .WAIT_CYCLES(W3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_we(b_req_we), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
        .A2(b_A2), .A1(b_A1), .A0(b_A0), .Select(b_Select), .wl(b_wl),
        .dec_err(b_dec_err), .par_err(b_par_err));

    int total = 0, bad = 0;
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction model: k counts edges since accept (0 = setup, 1..W = strobe, >W = response).
    bit         busy = 0;
    int         k = 0;
    bit         m_we = 0;
    logic [2:0] m_addr = 0, m_A = 0;
    logic [7:0] m_wdata = 0, exp_rd = 0;
    logic [7:0] mem [8] = '{default: 8'h00};
    bit         m_dec = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy = 0; k = 0; m_A = 0; exp_rd = 0; m_dec = 0;
            for (int i = 0; i < 8; i++) mem[i] = 8'h00;
        end else if (busy) begin
            if (k == W) begin
                logic [7:0] wv;
                wv = drive_wl(fault, m_addr);
                if ($onehot(wv) && wv[m_addr]) begin
                    if (m_we) begin mem[m_addr] = m_wdata; exp_rd = m_wdata; end
                    else exp_rd = mem[m_addr];
                end else begin
                    exp_rd = 8'h00; m_dec = 1;
                end
            end
            if (k > W && rsp_ready) busy = 0;
            k++;
        end else if (req_valid) begin
            busy = 1; k = 0;
            m_we = req_we; m_addr = req_addr; m_wdata = req_wdata; m_A = req_addr;
        end
    end

    bit chk_en = 0;
    always @(negedge clk) begin
        if (chk_en) begin
            check("req_ready", req_ready, !busy);
            check("select", Select, busy && k >= 1 && k <= W);
            check("addr_out", a_bus, m_A);
            check("rsp_valid", rsp_valid, busy && k > W);
            if (busy && k > W) check("rdata", rsp_rdata, exp_rd);
            check("dec_err", dec_err, m_dec);
            check("par_err", par_err, 1'b0);
        end
    end

    task automatic do_req(input bit we, input logic [2:0] a, input logic [7:0] d, input int hold,
                          output logic [7:0] rd, output int lat, output int sels);
        int n;
        rd = 0; lat = 0; sels = 0;
        req_we = we; req_addr = a; req_wdata = d; req_valid = 1; rsp_ready = (hold == 0);
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) check("accept_timeout", 1, 0);
        @(posedge clk); #1 req_valid = 0;
        n = 0;
        do begin
            @(negedge clk); n++;
            if (Select) sels++;
        end while (!rsp_valid && n < 50);
        if (n >= 50) check("rsp_timeout", 1, 0);
        lat = n - 1; rd = rsp_rdata;
        repeat (hold) begin
            req_valid = 1'($urandom); req_addr = 3'($urandom);
            @(negedge clk);
        end
        rsp_ready = 1;
        @(posedge clk); #1 rsp_ready = 0; req_valid = 0;
    endtask

    task automatic b_req(input bit we, input logic [2:0] a, input logic [7:0] d,
                         output logic [7:0] rd, output int first, output int sels);
        @(negedge clk);
        check("b_req_ready", b_req_ready, 1);
        b_req_we = we; b_req_addr = a; b_req_wdata = d; b_req_valid = 1;
        @(posedge clk); #1 b_req_valid = 0;
        first = 0; sels = 0; rd = 0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (b_Select) sels++;
            if (b_rsp_valid && first == 0) begin first = n; rd = b_rsp_rdata; end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd;
        int lat, sels;
        rst_n = 0;
        repeat (3) @(negedge clk);
        rst_n = 1;
        chk_en = 1;
        // 1: reset state and empty store
        check("rst_req_ready", req_ready, 1);
        check("rst_select", Select, 0);
        check("rst_addr", a_bus, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_dec_err", dec_err, 0);
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            do_req(0, 3'(i), 8'h00, 0, rd, lat, sels);
            check("empty_read", rd, 8'h00);
        end
        // 2: single write/read
        do_req(1, 3'd5, 8'hA5, 0, rd, lat, sels);
        check("wr5_sel_cycles", sels, 1);
        do_req(0, 3'd5, 8'h00, 0, rd, lat, sels);
        check("rd5_data", rd, 8'hA5);
        check("rd5_latency", lat, 2);
        do_req(0, 3'd4, 8'h00, 0, rd, lat, sels);
        check("rd4_data", rd, 8'h00);
        // 3: fill and read back
        for (int i = 0; i < 8; i++) do_req(1, 3'(i), 8'(8'h10 + i), 0, rd, lat, sels);
        for (int i = 0; i < 8; i++) begin
            do_req(0, 3'(i), 8'h00, 0, rd, lat, sels);
            check("fill_read", rd, 8'(8'h10 + i));
        end
        // 4: response back-pressure
        do_req(0, 3'd3, 8'h00, 5, rd, lat, sels);
        check("bp_rd3", rd, 8'h13);
        // 5: dead decoder during a write
        fault = 1;
        do_req(1, 3'd2, 8'hFF, 0, rd, lat, sels);
        fault = 0;
        check("fault_rdata", rd, 8'h00);
        check("fault_dec_err", dec_err, 1);
        do_req(0, 3'd2, 8'h00, 0, rd, lat, sels);
        check("fault_old_data", rd, 8'h12);
        check("dec_err_sticky", dec_err, 1);
        // randomized traffic with occasional decoder faults
        for (int t = 0; t < 150; t++) begin
            fault = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
            do_req(1'($urandom), 3'($urandom), 8'($urandom), int'($urandom_range(0, 3)), rd, lat, sels);
            fault = 0;
        end
        // long strobe instance
        b_req(1, 3'd6, 8'h77, rd, lat, sels);
        check("w3_sel_cycles", sels, 3);
        check("w3_first_rsp", lat, 5);
        b_req(0, 3'd6, 8'h00, rd, lat, sels);
        check("w3_read", rd, 8'h77);
        // 6: reset during the strobe of a write
        @(posedge clk); #1;
        req_we = 1; req_addr = 3'd6; req_wdata = 8'h77; req_valid = 1;
        @(negedge clk);
        @(posedge clk); #1 req_valid = 0;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_select", Select, 1);
        #2 rst_n = 0;
        #1;
        check("rst_drop_select", Select, 0);
        check("rst_drop_rsp", rsp_valid, 0);
        @(negedge clk);
        rst_n = 1;
        check("post_rst_dec_err", dec_err, 0);
        @(posedge clk); #1;
        do_req(0, 3'd6, 8'h00, 0, rd, lat, sels);
        check("aborted_write", rd, 8'h00);
        do_req(0, 3'd5, 8'h00, 0, rd, lat, sels);
        check("cleared_store", rd, 8'h00);
        b_req(0, 3'd6, 8'h00, rd, lat, sels);
        check("w3_cleared", rd, 8'h00);
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
